// File: rtl/ysyx_25040111_lsu_if.sv
// rtl/ysyx_25040111_lsu_if.sv - AXI4-Lite-style memory port between the LSU and its slave
interface ysyx_25040111_lsu_if;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;

    modport master (
        output araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        input  arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );

    modport slave (
        input  araddr, arvalid, rready, awaddr, awvalid, wdata, wstrb, wvalid, bready,
        output arready, rdata, rresp, rvalid, awready, wready, bresp, bvalid
    );
endinterface

// File: rtl/ysyx_25040111_lsu.sv
// rtl/ysyx_25040111_lsu.sv - load/store + write-back stage; YSYX_25040111_LSU_ERR_EN adds alignment/response error checking
module ysyx_25040111_lsu (
    input  logic        clock,
    input  logic        reset,
    input  logic        abt_valid,
    output logic        abt_ready,
    input  logic        abt_men,
    input  logic        abt_write,
    input  logic [31:0] abt_addr,
    input  logic [31:0] abt_wdata,
    input  logic [1:0]  abt_mask,
    input  logic        abt_rsign,
    input  logic [4:0]  abt_ard,
    input  logic [31:0] abt_rd,
    input  logic        abt_gen,
    input  logic [11:0] abt_acsr,
    input  logic [31:0] abt_csr,
    input  logic        abt_sen,
    ysyx_25040111_lsu_if.master bus,
    output logic        wb_valid,
    output logic        wb_gen,
    output logic [4:0]  wb_ard,
    output logic [31:0] wb_rd,
    output logic        wb_sen,
    output logic [11:0] wb_acsr,
`ifdef YSYX_25040111_LSU_ERR_EN
    output logic        lsu_err,
`endif
    output logic [31:0] wb_csr
);
    typedef enum logic [2:0] {S_IDLE, S_RADDR, S_RDATA, S_WREQ, S_WRESP, S_WB} state_t;

    state_t      state, state_nxt;
    logic [31:0] addr_q, wdata_q, rd_q, csr_q;
    logic [1:0]  mask_q;
    logic        rsign_q, gen_q, sen_q;
    logic [4:0]  ard_q;
    logic [11:0] acsr_q;
    logic        aw_done, w_done;
    logic        aw_fire, w_fire;
    logic        err_now;
    logic        enter_wb;
    logic [31:0] rshift, load_val;

    assign abt_ready   = (state == S_IDLE);
    assign wb_valid    = (state == S_WB);
    assign bus.araddr  = addr_q;
    assign bus.awaddr  = addr_q;
    assign bus.arvalid = (state == S_RADDR);
    assign bus.rready  = (state == S_RDATA);
    assign bus.awvalid = (state == S_WREQ) && !aw_done;
    assign bus.wvalid  = (state == S_WREQ) && !w_done;
    assign bus.bready  = (state == S_WRESP);
    assign bus.wdata   = wdata_q << {addr_q[1:0], 3'b000};
    assign aw_fire     = bus.awvalid && bus.awready;
    assign w_fire      = bus.wvalid && bus.wready;
    assign enter_wb    = (state != S_WB) && (state_nxt == S_WB);

    always_comb begin
        case (mask_q)
            2'b01:   bus.wstrb = 4'b0001 << addr_q[1:0];
            2'b10:   bus.wstrb = 4'b0011 << addr_q[1:0];
            2'b11:   bus.wstrb = 4'b1111;
            default: bus.wstrb = 4'b0000;
        endcase
    end

    // Lane-select the addressed byte/half into bit 0 before extension.
    assign rshift = bus.rdata >> {addr_q[1:0], 3'b000};
    always_comb begin
        case (mask_q)
            2'b01:   load_val = {{24{rsign_q & rshift[7]}}, rshift[7:0]};
            2'b10:   load_val = {{16{rsign_q & rshift[15]}}, rshift[15:0]};
            default: load_val = rshift;
        endcase
    end

`ifdef YSYX_25040111_LSU_ERR_EN
    logic misaligned_in;
    assign misaligned_in = ((abt_mask == 2'b10) && abt_addr[0]) ||
                           ((abt_mask == 2'b11) && (abt_addr[1:0] != 2'b00));
`else
    logic unused_resp;
    assign unused_resp = ^{bus.rresp, bus.bresp};
`endif

    always_comb begin
        state_nxt = state;
        err_now   = 1'b0;
        case (state)
            S_IDLE: begin
                if (abt_valid) begin
                    if (!abt_men)
                        state_nxt = S_WB;
`ifdef YSYX_25040111_LSU_ERR_EN
                    else if (misaligned_in) begin
                        state_nxt = S_WB;
                        err_now   = 1'b1;
                    end
`endif
                    else if (abt_write)
                        state_nxt = S_WREQ;
                    else
                        state_nxt = S_RADDR;
                end
            end
            S_RADDR: if (bus.arready) state_nxt = S_RDATA;
            S_RDATA: begin
                if (bus.rvalid) begin
                    state_nxt = S_WB;
`ifdef YSYX_25040111_LSU_ERR_EN
                    err_now   = (bus.rresp != 2'b00);
`endif
                end
            end
            S_WREQ: if ((aw_done || aw_fire) && (w_done || w_fire)) state_nxt = S_WRESP;
            S_WRESP: begin
                if (bus.bvalid) begin
                    state_nxt = S_WB;
`ifdef YSYX_25040111_LSU_ERR_EN
                    err_now   = (bus.bresp != 2'b00);
`endif
                end
            end
            S_WB:    state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state   <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            rd_q    <= '0;
            csr_q   <= '0;
            mask_q  <= '0;
            rsign_q <= 1'b0;
            gen_q   <= 1'b0;
            sen_q   <= 1'b0;
            ard_q   <= '0;
            acsr_q  <= '0;
            aw_done <= 1'b0;
            w_done  <= 1'b0;
            wb_gen  <= 1'b0;
            wb_ard  <= '0;
            wb_rd   <= '0;
            wb_sen  <= 1'b0;
            wb_acsr <= '0;
            wb_csr  <= '0;
`ifdef YSYX_25040111_LSU_ERR_EN
            lsu_err <= 1'b0;
`endif
        end else begin
            state <= state_nxt;
            if (state == S_IDLE && abt_valid) begin
                addr_q  <= abt_addr;
                wdata_q <= abt_wdata;
                rd_q    <= abt_rd;
                csr_q   <= abt_csr;
                mask_q  <= abt_mask;
                rsign_q <= abt_rsign;
                gen_q   <= abt_gen;
                sen_q   <= abt_sen;
                ard_q   <= abt_ard;
                acsr_q  <= abt_acsr;
            end
            // Per-channel completion flags live only while waiting in WREQ.
            aw_done <= (state == S_WREQ) && (state_nxt == S_WREQ) && (aw_done || aw_fire);
            w_done  <= (state == S_WREQ) && (state_nxt == S_WREQ) && (w_done || w_fire);
            // Write-back fields are captured on entry to WB so they hold between retires.
            if (enter_wb) begin
                wb_gen  <= ((state == S_IDLE) ? abt_gen : gen_q) && !err_now;
                wb_ard  <= (state == S_IDLE) ? abt_ard : ard_q;
                wb_rd   <= (state == S_IDLE) ? abt_rd : ((state == S_RDATA) ? load_val : rd_q);
                wb_sen  <= (state == S_IDLE) ? abt_sen : sen_q;
                wb_acsr <= (state == S_IDLE) ? abt_acsr : acsr_q;
                wb_csr  <= (state == S_IDLE) ? abt_csr : csr_q;
            end
`ifdef YSYX_25040111_LSU_ERR_EN
            if (enter_wb && err_now)
                lsu_err <= 1'b1;
`endif
        end
    end
endmodule

// File: tb/tb_ysyx_25040111_lsu.sv
// tb/tb_ysyx_25040111_lsu.sv - table-driven and randomized checks of ysyx_25040111_lsu against a transaction-level model
module tb_ysyx_25040111_lsu;
`ifdef YSYX_25040111_LSU_ERR_EN
    localparam bit ERR = 1'b1;
`else
    localparam bit ERR = 1'b0;
`endif

    logic        clock = 1'b0;
    logic        reset = 1'b1;
    logic        abt_valid, abt_ready, abt_men, abt_write, abt_rsign, abt_gen, abt_sen;
    logic [31:0] abt_addr, abt_wdata, abt_rd, abt_csr;
    logic [1:0]  abt_mask;
    logic [4:0]  abt_ard;
    logic [11:0] abt_acsr;
    logic        wb_valid, wb_gen, wb_sen;
    logic [4:0]  wb_ard;
    logic [31:0] wb_rd, wb_csr;
    logic [11:0] wb_acsr;
`ifdef YSYX_25040111_LSU_ERR_EN
    logic        lsu_err;
`endif

    int checks = 0;
    int errors = 0;
    bit exp_err = 1'b0;

    always #5 clock = ~clock;

    ysyx_25040111_lsu_if bus ();

    ysyx_25040111_lsu dut (
        .clock(clock), .reset(reset),
        .abt_valid(abt_valid), .abt_ready(abt_ready), .abt_men(abt_men), .abt_write(abt_write),
        .abt_addr(abt_addr), .abt_wdata(abt_wdata), .abt_mask(abt_mask), .abt_rsign(abt_rsign),
        .abt_ard(abt_ard), .abt_rd(abt_rd), .abt_gen(abt_gen),
        .abt_acsr(abt_acsr), .abt_csr(abt_csr), .abt_sen(abt_sen),
        .bus(bus),
        .wb_valid(wb_valid), .wb_gen(wb_gen), .wb_ard(wb_ard), .wb_rd(wb_rd),
        .wb_sen(wb_sen), .wb_acsr(wb_acsr),
`ifdef YSYX_25040111_LSU_ERR_EN
        .lsu_err(lsu_err),
`endif
        .wb_csr(wb_csr)
    );

    typedef struct {
        bit          men, write, rsign, gen, sen, noise;
        logic [31:0] addr, wdata, rd, csr, rdata;
        logic [1:0]  mask, rresp, bresp;
        logic [4:0]  ard;
        logic [11:0] acsr;
        int          ar_d, r_d, aw_d, w_d, b_d;
        logic [31:0] e_rd, e_wdata;
        logic [3:0]  e_wstrb;
        int          e_lat;
        bit          e_rbus, e_wbus, e_err;
    } vec_t;

    vec_t tbl[$];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t mk(bit men, bit write, logic [31:0] addr, logic [31:0] wdata,
                                logic [1:0] mask, bit rsign, logic [31:0] rd, logic [31:0] rdata,
                                int ar_d, int r_d, int aw_d, int w_d, int b_d, bit noise,
                                logic [31:0] e_rd, logic [31:0] e_wdata, logic [3:0] e_wstrb,
                                int e_lat, bit e_rbus, bit e_wbus);
        vec_t v;
        v.men = men; v.write = write; v.addr = addr; v.wdata = wdata; v.mask = mask;
        v.rsign = rsign; v.rd = rd; v.rdata = rdata; v.noise = noise;
        v.ard = 5'd5; v.gen = 1'b1; v.acsr = 12'h300; v.csr = rd ^ 32'hA5A5_0000; v.sen = 1'b1;
        v.rresp = 2'b00; v.bresp = 2'b00;
        v.ar_d = ar_d; v.r_d = r_d; v.aw_d = aw_d; v.w_d = w_d; v.b_d = b_d;
        v.e_rd = e_rd; v.e_wdata = e_wdata; v.e_wstrb = e_wstrb; v.e_lat = e_lat;
        v.e_rbus = e_rbus; v.e_wbus = e_wbus; v.e_err = 1'b0;
        return v;
    endfunction

    // Reference model: what one instruction should produce, from the access rules alone.
    function automatic vec_t model(input vec_t v);
        int          off;
        logic [31:0] sh;
        bit          mis;
        off = int'(v.addr % 4);
        mis = ERR && ((v.mask == 2'd2 && off % 2 == 1) || (v.mask == 2'd3 && off != 0));
        v.e_rbus = 0; v.e_wbus = 0; v.e_err = 0; v.e_wdata = 0; v.e_wstrb = 0;
        v.e_rd = v.rd; v.e_lat = 1;
        if (v.men && mis) begin
            v.e_err = 1;
        end else if (v.men && !v.write) begin
            v.e_rbus = 1;
            sh = v.rdata >> (8 * off);
            if (v.mask == 2'd1) begin
                v.e_rd = sh % 256;
                if (v.rsign && v.e_rd >= 128) v.e_rd = v.e_rd + 32'hFFFF_FF00;
            end else if (v.mask == 2'd2) begin
                v.e_rd = sh % 65536;
                if (v.rsign && v.e_rd >= 32768) v.e_rd = v.e_rd + 32'hFFFF_0000;
            end else begin
                v.e_rd = sh;
            end
            v.e_lat = v.ar_d + v.r_d + 3;
            v.e_err = ERR && (v.rresp != 0);
        end else if (v.men) begin
            v.e_wbus = 1;
            v.e_wdata = v.wdata << (8 * off);
            v.e_wstrb = (v.mask == 2'd1) ? 4'(1 << off) : (v.mask == 2'd2) ? 4'(3 << off) : 4'hF;
            v.e_lat = ((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + v.b_d + 3;
            v.e_err = ERR && (v.bresp != 0);
        end
        return v;
    endfunction

    function automatic vec_t rnd();
        vec_t v;
        int   off;
        v.men = ($urandom_range(0, 3) != 0); v.write = $urandom_range(0, 1);
        v.mask = 2'($urandom_range(1, 3)); v.rsign = $urandom_range(0, 1);
        off = $urandom_range(0, 3);
        if (!ERR || $urandom_range(0, 3) != 0) begin
            if (v.mask == 2'd2) off = off & 2;
            if (v.mask == 2'd3) off = 0;
        end
        v.addr = 32'h8000_0000 | ($urandom & 32'h0000_FFFC) | 32'(off);
        v.wdata = $urandom; v.rd = $urandom; v.rdata = $urandom; v.csr = $urandom;
        v.ard = 5'($urandom); v.acsr = 12'($urandom); v.gen = $urandom_range(0, 1); v.sen = $urandom_range(0, 1);
        v.rresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        v.bresp = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'd0;
        v.ar_d = $urandom_range(0, 3); v.r_d = $urandom_range(0, 3);
        v.aw_d = $urandom_range(0, 3); v.w_d = $urandom_range(0, 3); v.b_d = $urandom_range(0, 3);
        v.noise = $urandom_range(0, 1);
        return model(v);
    endfunction

    task automatic drive_abt(input vec_t v);
        abt_men = v.men; abt_write = v.write; abt_addr = v.addr; abt_wdata = v.wdata;
        abt_mask = v.mask; abt_rsign = v.rsign; abt_ard = v.ard; abt_rd = v.rd;
        abt_gen = v.gen; abt_acsr = v.acsr; abt_csr = v.csr; abt_sen = v.sen;
    endtask

    task automatic junk_abt();
        abt_men = $urandom_range(0, 1); abt_write = $urandom_range(0, 1); abt_addr = $urandom;
        abt_wdata = $urandom; abt_mask = 2'($urandom); abt_rsign = $urandom_range(0, 1);
        abt_ard = 5'($urandom); abt_rd = $urandom; abt_gen = $urandom_range(0, 1);
        abt_acsr = 12'($urandom); abt_csr = $urandom; abt_sen = $urandom_range(0, 1);
    endtask

    task automatic slave_idle();
        bus.arready = 0; bus.rvalid = 0; bus.rdata = 0; bus.rresp = 0;
        bus.awready = 0; bus.wready = 0; bus.bvalid = 0; bus.bresp = 0;
    endtask

    // Issue one instruction and act as a delayed slave until one cycle past the retire pulse.
    task automatic run(input vec_t v, input string tag);
        int ar_c = 0, r_c = 0, aw_c = 0, w_c = 0, b_c = 0;
        int wb_n = 0, wb_k = -1, bad_bus = 0, bad_busy = 0, b_first = -1, exp_b;
        bit rv, bv;
        logic [31:0] g_rd, g_csr;
        logic [4:0]  g_ard;
        logic [11:0] g_acsr;
        logic        g_gen, g_sen;
        g_rd = 0; g_csr = 0; g_ard = 0; g_acsr = 0; g_gen = 0; g_sen = 0;
        @(negedge clock);
        chk({tag, ":accept_ready"}, 32'(abt_ready), 32'd1);
        drive_abt(v);
        abt_valid = 1;
        @(negedge clock);
        abt_valid = 0;
        junk_abt();
        for (int k = 1; k <= 60; k++) begin
            if (wb_k >= 0 && k == wb_k + 1) begin
                chk({tag, ":wb_hold"}, wb_rd, g_rd);
                chk({tag, ":ready_after"}, 32'(abt_ready), 32'd1);
                break;
            end
            if (abt_ready) bad_busy++;
            if (bus.arvalid) begin
                if (bus.araddr !== v.addr) bad_bus++;
                bus.arready = (ar_c >= v.ar_d); ar_c++;
            end else bus.arready = 0;
            if (bus.rready) begin
                rv = (r_c >= v.r_d); r_c++;
                bus.rvalid = rv; bus.rdata = rv ? v.rdata : 32'hDEAD_BEEF; bus.rresp = rv ? v.rresp : 2'b11;
            end else begin
                bus.rvalid = v.noise; bus.rdata = 32'hDEAD_BEEF; bus.rresp = 2'b10;
            end
            if (bus.awvalid) begin
                if (bus.awaddr !== v.addr) bad_bus++;
                bus.awready = (aw_c >= v.aw_d); aw_c++;
            end else bus.awready = 0;
            if (bus.wvalid) begin
                if (bus.wdata !== v.e_wdata || bus.wstrb !== v.e_wstrb) bad_bus++;
                bus.wready = (w_c >= v.w_d); w_c++;
            end else bus.wready = 0;
            if (bus.bready) begin
                if (b_first < 0) b_first = k;
                bv = (b_c >= v.b_d); b_c++;
                bus.bvalid = bv; bus.bresp = bv ? v.bresp : 2'b11;
            end else begin
                bus.bvalid = v.noise; bus.bresp = 2'b01;
            end
            if (wb_valid) begin
                wb_n++;
                if (wb_k < 0) begin
                    wb_k = k; g_rd = wb_rd; g_ard = wb_ard; g_gen = wb_gen;
                    g_sen = wb_sen; g_acsr = wb_acsr; g_csr = wb_csr;
                end
            end
            @(negedge clock);
        end
        slave_idle();
        exp_b = v.e_wbus ? (((v.aw_d > v.w_d) ? v.aw_d : v.w_d) + 2) : -1;
        chk({tag, ":wb_count"}, 32'(wb_n), 32'd1);
        chk({tag, ":wb_latency"}, 32'(wb_k), 32'(v.e_lat));
        chk({tag, ":wb_rd"}, g_rd, v.e_rd);
        chk({tag, ":wb_ard"}, 32'(g_ard), 32'(v.ard));
        chk({tag, ":wb_gen"}, 32'(g_gen), 32'(v.gen && !v.e_err));
        chk({tag, ":wb_sen"}, 32'(g_sen), 32'(v.sen));
        chk({tag, ":wb_acsr"}, 32'(g_acsr), 32'(v.acsr));
        chk({tag, ":wb_csr"}, g_csr, v.csr);
        chk({tag, ":ar_cycles"}, 32'(ar_c), v.e_rbus ? 32'(v.ar_d + 1) : 32'd0);
        chk({tag, ":r_cycles"}, 32'(r_c), v.e_rbus ? 32'(v.r_d + 1) : 32'd0);
        chk({tag, ":aw_cycles"}, 32'(aw_c), v.e_wbus ? 32'(v.aw_d + 1) : 32'd0);
        chk({tag, ":w_cycles"}, 32'(w_c), v.e_wbus ? 32'(v.w_d + 1) : 32'd0);
        chk({tag, ":b_cycles"}, 32'(b_c), v.e_wbus ? 32'(v.b_d + 1) : 32'd0);
        chk({tag, ":bready_first"}, 32'(b_first), 32'(exp_b));
        chk({tag, ":bus_addr_data"}, 32'(bad_bus), 32'd0);
        chk({tag, ":busy_ready"}, 32'(bad_busy), 32'd0);
        if (v.e_err) exp_err = 1'b1;
`ifdef YSYX_25040111_LSU_ERR_EN
        chk({tag, ":lsu_err"}, 32'(lsu_err), 32'(exp_err));
`endif
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        vec_t v;
        abt_valid = 0;
        junk_abt();
        slave_idle();
        repeat (3) @(negedge clock);
        reset = 0;
        @(negedge clock);
        chk("rst:abt_ready", 32'(abt_ready), 32'd1);
        chk("rst:valids", {23'd0, bus.arvalid, bus.rready, bus.awvalid, bus.wvalid, bus.bready,
                           wb_valid, wb_gen, wb_sen, 1'b0}, 32'd0);
        chk("rst:araddr", bus.araddr, 32'd0);
        chk("rst:wdata", bus.wdata, 32'd0);
        chk("rst:wstrb", 32'(bus.wstrb), 32'd0);
        chk("rst:wb_rd", wb_rd, 32'd0);
`ifdef YSYX_25040111_LSU_ERR_EN
        chk("rst:lsu_err", 32'(lsu_err), 32'd0);
`endif

        //        men w  addr          wdata         m  s  rd            rdata         ar r aw w b nz  e_rd          e_wdata       strb lat rb wb
        tbl.push_back(mk(0, 0, 32'h0000_0000, 32'h0,        2'd0, 0, 32'h0000_1234, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0000_1234, 32'h0,        4'h0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 32'h8000_0003, 32'h0,        2'd1, 1, 32'h0000_0077, 32'h80FF_1122, 0, 0, 0, 0, 0, 0, 32'hFFFF_FF80, 32'h0,        4'h0, 3, 1, 0));
        tbl.push_back(mk(1, 0, 32'h8000_0003, 32'h0,        2'd1, 0, 32'h0000_0077, 32'h80FF_1122, 0, 0, 0, 0, 0, 1, 32'h0000_0080, 32'h0,        4'h0, 3, 1, 0));
        tbl.push_back(mk(1, 1, 32'h8000_0002, 32'h0000_ABCD, 2'd2, 0, 32'h0000_0042, 32'h0,        0, 0, 0, 0, 0, 0, 32'h0000_0042, 32'hABCD_0000, 4'hC, 3, 0, 1));
        tbl.push_back(mk(1, 1, 32'h8000_0010, 32'h1122_3344, 2'd3, 0, 32'h0000_0011, 32'h0,        0, 0, 0, 3, 0, 0, 32'h0000_0011, 32'h1122_3344, 4'hF, 6, 0, 1));
        tbl.push_back(mk(1, 0, 32'h8000_0008, 32'h0,        2'd3, 0, 32'h0000_0001, 32'h55AA_55AA, 3, 2, 0, 0, 0, 0, 32'h55AA_55AA, 32'h0,        4'h0, 8, 1, 0));
        tbl.push_back(mk(1, 0, 32'h8000_0006, 32'h0,        2'd2, 0, 32'h0000_0002, 32'h9ABC_1234, 1, 0, 0, 0, 0, 1, 32'h0000_9ABC, 32'h0,        4'h0, 4, 1, 0));
        tbl.push_back(mk(1, 0, 32'h8000_0006, 32'h0,        2'd2, 1, 32'h0000_0002, 32'h9ABC_1234, 0, 1, 0, 0, 0, 1, 32'hFFFF_9ABC, 32'h0,        4'h0, 4, 1, 0));
        tbl.push_back(mk(1, 1, 32'h8000_0001, 32'h0000_01FF, 2'd1, 0, 32'h0000_0003, 32'h0,        0, 0, 2, 1, 2, 1, 32'h0000_0003, 32'h0001_FF00, 4'h2, 7, 0, 1));
        tbl.push_back(mk(1, 0, 32'h8000_000C, 32'h0,        2'd3, 1, 32'h0000_0009, 32'hCAFE_F00D, 0, 0, 0, 0, 0, 1, 32'hCAFE_F00D, 32'h0,        4'h0, 3, 1, 0));
`ifdef YSYX_25040111_LSU_ERR_EN
        v = mk(1, 0, 32'h8000_0002, 32'h0, 2'd3, 0, 32'h0000_00AA, 32'h1234_5678, 0, 0, 0, 0, 0, 0,
               32'h0000_00AA, 32'h0, 4'h0, 1, 0, 0);
        v.e_err = 1; tbl.push_back(v);
        v = mk(1, 1, 32'h8000_0005, 32'h0000_BEEF, 2'd2, 0, 32'h0000_00BB, 32'h0, 0, 0, 0, 0, 0, 0,
               32'h0000_00BB, 32'h0, 4'h0, 1, 0, 0);
        v.e_err = 1; tbl.push_back(v);
        v = mk(1, 0, 32'h8000_0004, 32'h0, 2'd3, 0, 32'h0000_00CC, 32'h1234_5678, 0, 1, 0, 0, 0, 0,
               32'h1234_5678, 32'h0, 4'h0, 4, 1, 0);
        v.rresp = 2'b10; v.e_err = 1; tbl.push_back(v);
`endif
        for (int i = 0; i < tbl.size(); i++) run(tbl[i], $sformatf("tbl%0d", i));

        // Reset while a load waits for arready.
        v = mk(1, 0, 32'h8000_0040, 32'h0, 2'd3, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
        @(negedge clock);
        drive_abt(v); abt_valid = 1;
        @(negedge clock);
        abt_valid = 0;
        chk("rstmid_ld:arvalid_before", 32'(bus.arvalid), 32'd1);
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0; exp_err = 0;
        chk("rstmid_ld:arvalid", 32'(bus.arvalid), 32'd0);
        chk("rstmid_ld:rready", 32'(bus.rready), 32'd0);
        chk("rstmid_ld:abt_ready", 32'(abt_ready), 32'd1);

        // Reset after the AW half of a store has completed.
        v = mk(1, 1, 32'h8000_0020, 32'h600D_D00D, 2'd3, 0, 32'h0, 32'h0, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 0);
        @(negedge clock);
        drive_abt(v); abt_valid = 1;
        @(negedge clock);
        abt_valid = 0;
        chk("rstmid_st:aw_w_valid", {30'd0, bus.awvalid, bus.wvalid}, 32'd3);
        bus.awready = 1; bus.wready = 0;
        @(negedge clock);
        bus.awready = 0;
        chk("rstmid_st:aw_dropped", {30'd0, bus.awvalid, bus.wvalid}, 32'd1);
        reset = 1;
        @(negedge clock);
        reset = 0;
        chk("rstmid_st:aw_w_cleared", {30'd0, bus.awvalid, bus.wvalid}, 32'd0);
        chk("rstmid_st:abt_ready", 32'(abt_ready), 32'd1);
        run(mk(1, 1, 32'h8000_0024, 32'h0102_0304, 2'd3, 0, 32'h0000_0055, 32'h0, 0, 0, 1, 0, 1, 0,
               32'h0000_0055, 32'h0102_0304, 4'hF, 5, 0, 1), "post_rst_store");

        for (int i = 0; i < 40; i++) run(rnd(), $sformatf("rnd%0d", i));

`ifdef YSYX_25040111_LSU_ERR_EN
        run(model(mk(1, 0, 32'h8000_0002, 32'h0, 2'd3, 0, 32'h0000_00DD, 32'h0, 0, 0, 0, 0, 0, 0,
                     32'h0, 32'h0, 4'h0, 0, 0, 0)), "err_final");
        chk("err:sticky_before_reset", 32'(lsu_err), 32'd1);
        @(negedge clock);
        reset = 1;
        @(negedge clock);
        reset = 0; exp_err = 0;
        chk("err:cleared_by_reset", 32'(lsu_err), 32'd0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
